// File: rtl/hynoc_pkg.sv
// Shared constants, state encoding and route helpers for the hynoc router ports.
package hynoc_pkg;

    // Ingress sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQUEST  = 3'd1,
        ST_TRANSFER = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    // Flit = payload plus a stop bit on top
    function automatic int unsigned flit_width(input int unsigned payload_width);
        return payload_width + 1;
    endfunction

    // Stop bit sits just above the payload
    function automatic int unsigned stop_bit(input int unsigned payload_width);
        return payload_width;
    endfunction

    // Route bits consumed per hop
    function automatic int unsigned route_width(input int unsigned nb_ports);
        return (nb_ports < 2) ? 1 : $clog2(nb_ports);
    endfunction

    // Bits needed to index one of the NB_PORTS-1 egresses
    function automatic int unsigned sel_width(input int unsigned nb_ports);
        return (nb_ports <= 2) ? 1 : $clog2(nb_ports - 1);
    endfunction

    // Absolute port number to egress index; the own port is skipped
    function automatic int unsigned abs_to_rel(input int unsigned r, input int unsigned port_index);
        if (r < port_index || r == 0) begin
            return r;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/hynoc_route_decode.sv
// Source-route header decode: egress select, route validity and the header
// with the consumed route bits stripped off.
module hynoc_route_decode
    import hynoc_pkg::*;
#(
    parameter  int unsigned NB_PORTS      = 5,
    parameter  int unsigned PORT_INDEX    = 0,
    parameter  int unsigned PAYLOAD_WIDTH = 32,
    localparam int unsigned FLIT_WIDTH    = flit_width(PAYLOAD_WIDTH),
    localparam int unsigned SEL_WIDTH     = sel_width(NB_PORTS)
) (
    input  logic [FLIT_WIDTH-1:0] flit,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  valid,
    output logic [FLIT_WIDTH-1:0] header
);

    localparam int unsigned ROUTE_WIDTH = route_width(NB_PORTS);
    localparam int unsigned STOP_BIT    = stop_bit(PAYLOAD_WIDTH);

    logic [ROUTE_WIDTH-1:0] route;

    // Decode the route field and build the forwarded header
    always_comb begin
        route  = flit[ROUTE_WIDTH-1:0];
        valid  = (32'(route) != PORT_INDEX) && (32'(route) < NB_PORTS);
        sel    = SEL_WIDTH'(abs_to_rel(32'(route), PORT_INDEX));
        header = {flit[STOP_BIT], flit[PAYLOAD_WIDTH-1:0] >> ROUTE_WIDTH};
    end

endmodule

// File: rtl/hynoc_ingress.sv
// Router port input stage: pops flits from the FWFT input FIFO, decodes the
// source route, arbitrates for the matching egress and streams the packet.
module hynoc_ingress
    import hynoc_pkg::*;
#(
    parameter  int unsigned NB_PORTS      = 5,
    parameter  int unsigned PORT_INDEX    = 0,
    parameter  int unsigned PAYLOAD_WIDTH = 32,
    parameter  int unsigned FLIT_WIDTH    = flit_width(PAYLOAD_WIDTH),
    localparam int unsigned NB_EGRESS     = NB_PORTS - 1
) (
    input  logic                  router_clk,
    input  logic                  router_arst_n,
    input  logic                  rempty,
    input  logic [FLIT_WIDTH-1:0] rdata,
    output logic                  ren,
    output logic [NB_EGRESS-1:0]  to_egress_request,
    output logic [NB_EGRESS-1:0]  to_egress_write,
    output logic [FLIT_WIDTH-1:0] to_egress_data,
    input  logic [NB_EGRESS-1:0]  from_egress_grant,
    input  logic [NB_EGRESS-1:0]  from_egress_afull,
    output logic                  route_error
);

    localparam int unsigned SEL_WIDTH = sel_width(NB_PORTS);
    localparam int unsigned STOP_BIT  = FLIT_WIDTH - 1;

    state_t                state;
    state_t                state_next;
    logic [NB_EGRESS-1:0]  sel_oh;
    logic [NB_EGRESS-1:0]  sel_oh_next;
    logic                  first;
    logic                  first_next;

    logic [SEL_WIDTH-1:0]  dec_sel;
    logic                  dec_valid;
    logic [FLIT_WIDTH-1:0] dec_header;

    logic                  grant_sel;
    logic                  afull_sel;
    logic                  stop;
    logic                  xfer;

    logic [NB_EGRESS-1:0]  request_next;
    logic [NB_EGRESS-1:0]  write_next;
    logic [FLIT_WIDTH-1:0] data_next;
    logic                  error_next;

    hynoc_route_decode #(
        .NB_PORTS      (NB_PORTS),
        .PORT_INDEX    (PORT_INDEX),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) u_route_decode (
        .flit   (rdata),
        .sel    (dec_sel),
        .valid  (dec_valid),
        .header (dec_header)
    );

    // Handshake qualifiers for the latched egress
    always_comb begin
        grant_sel = |(from_egress_grant & sel_oh);
        afull_sel = |(from_egress_afull & sel_oh);
        stop      = rdata[STOP_BIT];
        xfer      = (state == ST_TRANSFER) && grant_sel && !afull_sel && !rempty;
    end

    // State register
    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!rempty) begin
                    state_next = dec_valid ? ST_REQUEST : ST_DROP;
                end
            end
            ST_REQUEST: begin
                if (grant_sel) begin
                    state_next = ST_TRANSFER;
                end
            end
            ST_TRANSFER: begin
                if (xfer && stop) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Leave only once the egress has dropped its grant, so the
                // next packet cannot ride on a stale grant
                if (!grant_sel) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!rempty && stop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and datapath next values; ren is the only combinational output
    always_comb begin
        ren          = 1'b0;
        request_next = '0;
        write_next   = '0;
        data_next    = to_egress_data;
        error_next   = 1'b0;
        sel_oh_next  = sel_oh;
        first_next   = first;
        case (state)
            ST_IDLE: begin
                if (!rempty && dec_valid) begin
                    sel_oh_next = NB_EGRESS'(1) << dec_sel;
                    first_next  = 1'b1;
                end
            end
            ST_REQUEST: begin
                request_next = sel_oh;
            end
            ST_TRANSFER: begin
                // Request held through the cycle of the last write
                request_next = sel_oh;
                if (xfer) begin
                    ren        = 1'b1;
                    write_next = sel_oh;
                    data_next  = first ? dec_header : rdata;
                    first_next = 1'b0;
                end
            end
            ST_DROP: begin
                ren        = !rempty;
                error_next = !rempty && stop;
            end
            default: ;
        endcase
    end

    // Registered outputs and per-packet context
    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            to_egress_request <= '0;
            to_egress_write   <= '0;
            to_egress_data    <= '0;
            route_error       <= 1'b0;
            sel_oh            <= '0;
            first             <= 1'b0;
        end else begin
            to_egress_request <= request_next;
            to_egress_write   <= write_next;
            to_egress_data    <= data_next;
            route_error       <= error_next;
            sel_oh            <= sel_oh_next;
            first             <= first_next;
        end
    end

endmodule

// File: tb/tb_hynoc_ingress.sv
// Bench for hynoc_ingress at NB_PORTS=5, PORT_INDEX=1, 32-bit payload.
module tb_hynoc_ingress;

    localparam int unsigned NB_PORTS      = 5;
    localparam int unsigned PORT_INDEX    = 1;
    localparam int unsigned PAYLOAD_WIDTH = 32;
    localparam int unsigned FW            = PAYLOAD_WIDTH + 1;
    localparam int unsigned NE            = NB_PORTS - 1;
    localparam int unsigned RW            = 3;

    logic          router_clk    = 1'b0;
    logic          router_arst_n = 1'b0;
    logic          rempty        = 1'b1;
    logic [FW-1:0] rdata         = '0;
    logic          ren;
    logic [NE-1:0] to_egress_request;
    logic [NE-1:0] to_egress_write;
    logic [FW-1:0] to_egress_data;
    logic [NE-1:0] from_egress_grant = '0;
    logic [NE-1:0] from_egress_afull = '0;
    logic          route_error;

    logic [FW-1:0]    fifo [$];
    logic [NE+FW-1:0] sb [$];
    logic [NE+FW-1:0] exp_w;

    int n_vec      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int pops       = 0;
    int wr_count   = 0;
    int wr_first   = -1;
    int wr_last    = -1;
    int err_count  = 0;
    int extra_hold = 0;
    int hold_left [NE];
    logic [NE-1:0] req_seen   = '0;
    logic [NE-1:0] grant_prev = '0;

    always #5 router_clk = ~router_clk;

    hynoc_ingress #(
        .NB_PORTS      (NB_PORTS),
        .PORT_INDEX    (PORT_INDEX),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) dut (
        .router_clk        (router_clk),
        .router_arst_n     (router_arst_n),
        .rempty            (rempty),
        .rdata             (rdata),
        .ren               (ren),
        .to_egress_request (to_egress_request),
        .to_egress_write   (to_egress_write),
        .to_egress_data    (to_egress_data),
        .from_egress_grant (from_egress_grant),
        .from_egress_afull (from_egress_afull),
        .route_error       (route_error)
    );

    always @(posedge router_clk) cyc++;

    // FWFT input FIFO: pop on ren at the edge, head updated just after
    always @(posedge router_clk) begin
        logic do_pop;
        do_pop = router_arst_n && ren;
        #1;
        if (do_pop && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        rempty = (fifo.size() == 0);
        rdata  = rempty ? '0 : fifo[0];
    end

    // Egress grant model: registered grant follows request, optionally held
    always @(posedge router_clk) begin
        logic [NE-1:0] rq;
        rq = to_egress_request;
        #1;
        for (int i = 0; i < NE; i++) begin
            if (rq[i]) begin
                from_egress_grant[i] = 1'b1;
                hold_left[i]         = extra_hold;
            end else if (from_egress_grant[i] && hold_left[i] > 0) begin
                hold_left[i]--;
            end else begin
                from_egress_grant[i] = 1'b0;
            end
        end
    end

    // Egress-side sink: scoreboard pop on every write, plus protocol checks
    always @(negedge router_clk) begin
        if (router_arst_n) begin
            if (route_error) err_count++;
            req_seen = req_seen | to_egress_request;
            if (to_egress_write != '0) begin
                wr_count++;
                if (wr_first < 0) wr_first = cyc;
                wr_last = cyc;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sink_write: got write=%b data=%h, expected no write", to_egress_write, to_egress_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({to_egress_write, to_egress_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL sink_write: got write=%b data=%h, expected write=%b data=%h",
                                 to_egress_write, to_egress_data, exp_w[NE+FW-1:FW], exp_w[FW-1:0]);
                    end
                end
                n_vec++;
                if (!$onehot(to_egress_write) || (to_egress_write & ~to_egress_request) != '0) begin
                    n_err++;
                    $display("FAIL write_protocol: got write=%b request=%b, expected one-hot write covered by request",
                             to_egress_write, to_egress_request);
                end
            end
            if (to_egress_request != '0) begin
                n_vec++;
                if (!$onehot(to_egress_request) || (to_egress_request & grant_prev & ~from_egress_grant) != '0) begin
                    n_err++;
                    $display("FAIL request_protocol: got request=%b grant=%b, expected one-hot request and no grant drop",
                             to_egress_request, from_egress_grant);
                end
            end
        end
        grant_prev = from_egress_grant;
    end

    // Queue a packet into the input FIFO and its expected egress writes
    task automatic push_packet(input logic [31:0] hdr, input int nflits);
        int unsigned   route;
        bit            valid;
        logic [NE-1:0] mask;
        logic [31:0]   pl;
        logic          stop;
        route = int'(hdr[RW-1:0]);
        valid = (route != PORT_INDEX) && (route < NB_PORTS);
        mask  = valid ? (NE'(1) << ((route < PORT_INDEX) ? route : route - 1)) : '0;
        for (int k = 0; k < nflits; k++) begin
            pl   = (k == 0) ? hdr : $urandom;
            stop = (k == nflits - 1);
            fifo.push_back({stop, pl});
            if (valid) sb.push_back({mask, stop, (k == 0) ? (pl >> RW) : pl});
        end
    endtask

    // Wait until every queued flit is consumed and the handshake is idle
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || fifo.size() != 0 || to_egress_request != '0 || from_egress_grant != '0) && n < 300) begin
            @(negedge router_clk);
            n++;
        end
        n_vec++;
        if (n >= 300) begin
            n_err++;
            $display("FAIL %s_drain: got %0d flits still expected after %0d cycles, expected 0", name, sb.size(), n);
        end
        repeat (3) @(negedge router_clk);
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (wr_count < target && n < 100) begin
            @(negedge router_clk);
            #1;
            n++;
        end
        n_vec++;
        if (wr_count < target) begin
            n_err++;
            $display("FAIL %s_writes: got %0d writes, expected %0d", name, wr_count, target);
        end
    endtask

    task automatic clear_write_stats();
        wr_count = 0;
        wr_first = -1;
        wr_last  = -1;
    endtask

    task automatic test_reset();
        router_arst_n = 1'b0;
        repeat (3) @(negedge router_clk);
        n_vec += 5;
        if (to_egress_request !== '0) begin n_err++; $display("FAIL reset_request: got %b, expected 0", to_egress_request); end
        if (to_egress_write !== '0)   begin n_err++; $display("FAIL reset_write: got %b, expected 0", to_egress_write); end
        if (to_egress_data !== '0)    begin n_err++; $display("FAIL reset_data: got %h, expected 0", to_egress_data); end
        if (route_error !== 1'b0)     begin n_err++; $display("FAIL reset_error: got %b, expected 0", route_error); end
        if (ren !== 1'b0)             begin n_err++; $display("FAIL reset_ren: got %b, expected 0", ren); end
        router_arst_n = 1'b1;
        repeat (3) @(negedge router_clk);
        n_vec++;
        if (to_egress_request !== '0 || ren !== 1'b0) begin
            n_err++;
            $display("FAIL idle_empty: got request=%b ren=%b, expected 0/0", to_egress_request, ren);
        end
    endtask

    task automatic test_basic_route();
        clear_write_stats();
        push_packet(32'h0000_0003, 3);
        // header appears just after the next edge; request follows two edges later
        @(posedge router_clk); #2;
        n_vec++;
        if (to_egress_request !== 4'b0000) begin n_err++; $display("FAIL basic_req_c0: got %b, expected 0000", to_egress_request); end
        @(posedge router_clk); #2;
        n_vec++;
        if (to_egress_request !== 4'b0000) begin n_err++; $display("FAIL basic_req_c1: got %b, expected 0000", to_egress_request); end
        @(posedge router_clk); #2;
        n_vec++;
        if (to_egress_request !== 4'b0100) begin n_err++; $display("FAIL basic_req_c2: got %b, expected 0100", to_egress_request); end
        wait_writes(3, "basic");
        @(negedge router_clk); #1;
        n_vec += 2;
        if (to_egress_request !== '0 || to_egress_write !== '0) begin
            n_err++;
            $display("FAIL basic_release: got request=%b write=%b, expected 0000/0000", to_egress_request, to_egress_write);
        end
        if (wr_last - wr_first != 2) begin
            n_err++;
            $display("FAIL basic_burst: got write span %0d cycles, expected 2", wr_last - wr_first);
        end
        wait_drain("basic");
    endtask

    task automatic test_route_below();
        int n;
        push_packet(32'h0000_0018, 2);
        n = 0;
        while (to_egress_request == '0 && n < 20) begin
            @(negedge router_clk); #1;
            n++;
        end
        n_vec++;
        if (to_egress_request !== 4'b0001) begin
            n_err++;
            $display("FAIL below_request: got %b, expected 0001", to_egress_request);
        end
        wait_drain("below");
    endtask

    task automatic test_afull_stall();
        clear_write_stats();
        push_packet(32'h1234_5673, 6);
        wait_writes(2, "afull_pre");
        from_egress_afull = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (ren !== 1'b0) begin n_err++; $display("FAIL afull_ren: got %b at stall cycle %0d, expected 0", ren, c); end
            @(negedge router_clk); #1;
            n_vec++;
            if (to_egress_write !== '0) begin n_err++; $display("FAIL afull_write: got %b at stall cycle %0d, expected 0000", to_egress_write, c); end
        end
        from_egress_afull = '0;
        wait_drain("afull");
        n_vec += 2;
        if (wr_count != 6) begin n_err++; $display("FAIL afull_count: got %0d writes, expected 6", wr_count); end
        if (wr_last - wr_first != 9) begin n_err++; $display("FAIL afull_span: got span %0d cycles, expected 9", wr_last - wr_first); end
    endtask

    task automatic test_invalid_route();
        int pops0, err0, n;
        pops0    = pops;
        err0     = err_count;
        req_seen = '0;
        push_packet(32'h0000_0001, 2);
        push_packet(32'h0000_00AF, 2);
        n = 0;
        while (fifo.size() != 0 && n < 50) begin
            @(negedge router_clk);
            n++;
        end
        repeat (5) @(negedge router_clk);
        n_vec += 3;
        if (pops - pops0 != 4)       begin n_err++; $display("FAIL invalid_pops: got %0d, expected 4", pops - pops0); end
        if (err_count - err0 != 2)   begin n_err++; $display("FAIL invalid_errors: got %0d error cycles, expected 2", err_count - err0); end
        if (req_seen !== '0)         begin n_err++; $display("FAIL invalid_request: got %b, expected 0000", req_seen); end
        push_packet(32'h0000_0004, 1);
        wait_drain("invalid_recover");
    endtask

    task automatic test_back_to_back();
        int   fall_cyc, rise2, rises, n;
        logic g_prev, r_prev;
        extra_hold = 2;
        fall_cyc   = -1;
        rise2      = -1;
        rises      = 0;
        g_prev     = 1'b0;
        r_prev     = 1'b0;
        push_packet(32'h0000_0004, 1);
        push_packet(32'h0000_0014, 1);
        n = 0;
        while (rise2 < 0 && n < 100) begin
            @(negedge router_clk); #1;
            if (to_egress_request[3] && !r_prev) begin
                rises++;
                if (rises == 2) rise2 = cyc;
            end
            if (!from_egress_grant[3] && g_prev && rises == 1 && fall_cyc < 0) fall_cyc = cyc;
            g_prev = from_egress_grant[3];
            r_prev = to_egress_request[3];
            n++;
        end
        // first grant-low cycle G: RELEASE exits at G+1 (IDLE), REQUEST at G+2, request seen at G+3
        n_vec++;
        if (fall_cyc < 0 || rise2 - fall_cyc != 3) begin
            n_err++;
            $display("FAIL b2b_gap: got grant fall at %0d and second request at %0d, expected a gap of 3", fall_cyc, rise2);
        end
        wait_drain("b2b");
        extra_hold = 0;
    endtask

    task automatic test_reset_mid_packet();
        int n;
        clear_write_stats();
        push_packet(32'h0000_0003, 8);
        wait_writes(2, "rst_pre");
        #2;
        router_arst_n = 1'b0;
        #1;
        n_vec += 4;
        if (to_egress_request !== '0) begin n_err++; $display("FAIL rst_request: got %b, expected 0000", to_egress_request); end
        if (to_egress_write !== '0)   begin n_err++; $display("FAIL rst_write: got %b, expected 0000", to_egress_write); end
        if (to_egress_data !== '0)    begin n_err++; $display("FAIL rst_data: got %h, expected 0", to_egress_data); end
        if (route_error !== 1'b0)     begin n_err++; $display("FAIL rst_error: got %b, expected 0", route_error); end
        fifo.delete();
        sb.delete();
        repeat (3) @(negedge router_clk);
        router_arst_n = 1'b1;
        repeat (2) @(negedge router_clk);
        push_packet(32'h0000_0002, 2);
        n = 0;
        while (to_egress_request == '0 && n < 20) begin
            @(negedge router_clk); #1;
            n++;
        end
        n_vec++;
        if (to_egress_request !== 4'b0010) begin
            n_err++;
            $display("FAIL rst_recover_request: got %b, expected 0010", to_egress_request);
        end
        wait_drain("rst_recover");
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_route_below();
        test_afull_stall();
        test_invalid_route();
        test_back_to_back();
        test_reset_mid_packet();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d undelivered flits, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
